// File: rtl/conv_buffer_loader_pkg.sv
// conv_buffer_loader_pkg: shared FSM state encoding, width defaults and layer-parameter field offsets
package conv_buffer_loader_pkg;
  typedef enum logic [2:0] {IDLE, PARA, CLR, WEI, FTM, DONE} state_t;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int B_PARA_DEF = 64;
  localparam int B_CNT_DEF = 16;
  localparam int PARA_STRIDE_LSB = 0;
  localparam int PARA_STRIDE_W = 2;
  localparam int PARA_PAD_LSB = 2;
  localparam int PARA_PAD_W = 2;
  localparam int PARA_W_LSB = 4;
  localparam int PARA_W_W = 2;
  localparam int PARA_H_LSB = 6;
  localparam int PARA_H_W = 2;
  localparam int PARA_C1_LSB = 8;
  localparam int PARA_C1_W = 12;
endpackage

// File: rtl/beat_counter.sv
// beat_counter: loadable down-counter with a zero flag marking the last remaining beat
// Ports: clk/rstn clock and async active-low reset; load/load_val reload (wins over dec);
//        dec decrement by one; zero high when the count is 0.
module beat_counter
  import conv_buffer_loader_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/conv_buffer_loader.sv
// conv_buffer_loader: sequences one layer load (params, buffer clear, per-unit weights, feature map) from a DDR stream
// Ports: cmd_* command handshake and word counts; s_* input stream; para/para_we layer parameters;
//        fb_clr/wb_clr buffer clears; fb_we broadcast / wb_we one-hot write strobes with data di
//        (one cycle after each stream handshake); fb_full/wb_full backpressure; busy/done status.
// Optional: CONV_BUFFER_LOADER_STALL_CNT_EN adds stall_cnt, saturating count of stalled offered beats.
module conv_buffer_loader
  import conv_buffer_loader_pkg::*;
#(
  parameter int N_CONV_UNIT = 8,
  parameter int N_KERNEL    = 4,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int B_PARA      = B_PARA_DEF,
  parameter int B_CNT       = B_CNT_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [B_PARA-1:0]      cmd_para,
  input  logic [B_CNT-1:0]       cmd_ftm_words,
  input  logic [B_CNT-1:0]       cmd_wei_words,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [B_PARA-1:0]      para,
  output logic                   para_we,
  output logic                   fb_clr,
  output logic                   wb_clr,
  output logic                   fb_we,
  output logic [N_CONV_UNIT-1:0] wb_we,
  output logic [DATA_WIDTH-1:0]  di,
  input  logic [N_CONV_UNIT-1:0] fb_full,
  input  logic [N_CONV_UNIT-1:0] wb_full,
`ifdef CONV_BUFFER_LOADER_STALL_CNT_EN
  output logic [31:0]            stall_cnt,
`endif
  output logic                   busy,
  output logic                   done
);
  localparam int CW = B_CNT + $clog2(N_KERNEL);
  localparam int UW = N_CONV_UNIT > 1 ? $clog2(N_CONV_UNIT) : 1;
  state_t state, nxt;
  logic [B_CNT-1:0] ftm_words, wei_words;
  logic [UW-1:0] unit;
  logic hs, wei_zero, ftm_zero, unit_end, last_unit;
  assign hs = s_valid && s_ready;
  assign last_unit = unit == UW'(N_CONV_UNIT - 1);
  assign unit_end = state == WEI && hs && wei_zero;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign para_we = state == PARA;
  assign fb_clr = state == CLR;
  assign wb_clr = state == CLR;
  assign done = state == DONE;
  assign s_ready = state == WEI ? !wb_full[unit] : state == FTM ? !(|fb_full) : 1'b0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cmd_valid ? PARA : IDLE;
      PARA:    nxt = CLR;
      CLR:     nxt = wei_words != '0 ? WEI : ftm_words != '0 ? FTM : DONE;
      WEI:     nxt = unit_end && last_unit ? (ftm_words != '0 ? FTM : DONE) : WEI;
      FTM:     nxt = hs && ftm_zero ? DONE : FTM;
      default: nxt = IDLE;
    endcase
  end
  // Counters hold beats remaining minus one, so the zero flag marks the final beat and the
  // next unit reloads on that same handshake, giving back-to-back unit transitions.
  beat_counter #(.W(CW)) u_wei_cnt (
    .clk(clk), .rstn(rstn),
    .load(state == CLR || unit_end),
    .load_val(CW'(wei_words) * CW'(N_KERNEL) - 1'b1),
    .dec(state == WEI && hs),
    .zero(wei_zero)
  );
  beat_counter #(.W(B_CNT)) u_ftm_cnt (
    .clk(clk), .rstn(rstn),
    .load(state == CLR),
    .load_val(ftm_words - 1'b1),
    .dec(state == FTM && hs),
    .zero(ftm_zero)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      para <= '0;
      ftm_words <= '0;
      wei_words <= '0;
      unit <= '0;
      di <= '0;
      fb_we <= 1'b0;
      wb_we <= '0;
    end else begin
      state <= nxt;
      if (cmd_valid && cmd_ready) begin
        para <= cmd_para;
        ftm_words <= cmd_ftm_words;
        wei_words <= cmd_wei_words;
      end
      unit <= state == CLR ? '0 : unit_end && !last_unit ? unit + 1'b1 : unit;
      if (hs) di <= s_data;
      fb_we <= hs && state == FTM;
      wb_we <= hs && state == WEI ? N_CONV_UNIT'(1) << unit : '0;
    end
`ifdef CONV_BUFFER_LOADER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) stall_cnt <= '0;
    else if (cmd_valid && cmd_ready) stall_cnt <= '0;
    else if ((state == WEI || state == FTM) && s_valid && !s_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_conv_buffer_loader.sv
// tb_conv_buffer_loader: directed and randomized checks of conv_buffer_loader against a beat-order reference model
module tb_conv_buffer_loader;
  localparam int NU = 2, NK = 4, DW = 64, BP = 64, BC = 16;
  logic clk = 1'b0, rstn = 1'b0, cmd_valid = 1'b0, s_valid = 1'b0;
  logic cmd_ready, s_ready, para_we, fb_clr, wb_clr, fb_we, busy, done;
  logic [BP-1:0] cmd_para = '0, para;
  logic [BC-1:0] cmd_ftm_words = '0, cmd_wei_words = '0;
  logic [DW-1:0] s_data = '0, di;
  logic [NU-1:0] wb_we, fb_full = '0, wb_full = '0;
`ifdef CONV_BUFFER_LOADER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int checks = 0, errors = 0;
  int wb_cnt = 0, fb_cnt = 0;
  int mode_g, idx, total, stall_left;
  bit stalled;
  logic [NU:0] exp_we_q[$];
  logic [DW-1:0] exp_di_q[$];
  logic [DW-1:0] src_q[$];

  conv_buffer_loader #(.N_CONV_UNIT(NU), .N_KERNEL(NK), .DATA_WIDTH(DW), .B_PARA(BP), .B_CNT(BC)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_para(cmd_para),
    .cmd_ftm_words(cmd_ftm_words), .cmd_wei_words(cmd_wei_words), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .para(para), .para_we(para_we), .fb_clr(fb_clr), .wb_clr(wb_clr), .fb_we(fb_we),
    .wb_we(wb_we), .di(di), .fb_full(fb_full), .wb_full(wb_full),
`ifdef CONV_BUFFER_LOADER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the next beat the reference model expects.
  always @(negedge clk) if (rstn && (|wb_we || fb_we)) begin
    if (|wb_we) wb_cnt++;
    if (fb_we) fb_cnt++;
    checks++;
    assert (exp_we_q.size() > 0) else begin
      errors++;
      $error("FAIL extra_beat: observed we=%b di=%h expected no beat", {wb_we, fb_we}, di);
    end
    if (exp_we_q.size() > 0) begin
      checks++;
      assert ({wb_we, fb_we, di} === {exp_we_q[0], exp_di_q[0]}) else begin
        errors++;
        $error("FAIL beat: observed we=%b di=%h expected we=%b di=%h", {wb_we, fb_we}, di, exp_we_q[0], exp_di_q[0]);
      end
      void'(exp_we_q.pop_front());
      void'(exp_di_q.pop_front());
    end
  end

  task automatic drive();
    s_valid = mode_g == 1 ? ($urandom_range(0, 9) < 7) : 1'b1;
    s_data = idx < total ? src_q[idx] : {$urandom, $urandom};
    wb_full = mode_g == 1 ? NU'($urandom & $urandom) : '0;
    fb_full = mode_g == 1 ? NU'($urandom & $urandom) : '0;
    if (((mode_g == 2 && idx == 3) || (mode_g == 5 && idx == 2)) && !stalled) begin
      stalled = 1'b1;
      stall_left = mode_g == 2 ? 10 : 7;
    end
    if (stall_left > 0) begin
      if (mode_g == 2) wb_full[0] = 1'b1;
      else fb_full = '1;
      stall_left--;
    end
  endtask

  // mode: 0 clean, 1 random, 2 weight stall, 3 reset mid-FTM, 4 hold cmd_valid, 5 feature stall
  task automatic run_cmd(input int wei, input int ftm, input int mode);
    logic [BP-1:0] p;
    logic [DW-1:0] d;
    int t, t_para, t_done, nw;
    bit hs, fin;
    mode_g = mode;
    p = {$urandom, $urandom};
    nw = NU * NK * wei;
    total = nw + ftm;
    src_q.delete();
    exp_we_q.delete();
    exp_di_q.delete();
    for (int j = 0; j < total; j++) begin
      d = {$urandom, $urandom};
      src_q.push_back(d);
      exp_di_q.push_back(d);
      exp_we_q.push_back(j < nw ? {NU'(1) << (j / (NK * wei)), 1'b0} : {{NU{1'b0}}, 1'b1});
    end
    wb_cnt = 0;
    fb_cnt = 0;
    cmd_para = p;
    cmd_wei_words = BC'(wei);
    cmd_ftm_words = BC'(ftm);
    cmd_valid = 1'b1;
    for (t = 0; t < 50 && !cmd_ready; t++) @(negedge clk);
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    if (mode != 4) cmd_valid = 1'b0;
    idx = 0;
    stall_left = 0;
    stalled = 1'b0;
    fin = 1'b0;
    t_para = -1;
    t_done = -1;
    drive();
    for (t = 0; t < 3000 && !fin; t++) begin
      @(negedge clk); #1;
      hs = s_valid && s_ready;
      chk("cmd_ready_vs_busy", cmd_ready, !busy);
      if (para_we) begin
        t_para = t;
        chk("para", para, p);
      end
      if (fb_clr) chk("clr_pair", wb_clr, 1);
      if (mode == 2 && wb_full[0]) begin
        chk("stall_s_ready", s_ready, 0);
        if (stall_left < 9) chk("stall_wb_we", wb_we, 0);
      end
      if (mode == 3 && fb_cnt == 4) begin
        rstn = 1'b0;
        #1;
        chk("rst_fb_we", fb_we, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_di", di, 0);
        chk("rst_para", para, 0);
        exp_we_q.delete();
        exp_di_q.delete();
        s_valid = 1'b0;
        @(posedge clk); #3;
        rstn = 1'b1;
        fin = 1'b1;
      end else if (done) begin
        t_done = t;
        fin = 1'b1;
        chk("all_beats_delivered", exp_we_q.size(), 0);
      end
      if (!fin) begin
        @(posedge clk); #1;
        if (hs) idx++;
        drive();
      end
    end
    chk("done_seen", fin, 1);
    if (mode != 3) begin
      chk("wb_pulses", wb_cnt, nw);
      chk("fb_pulses", fb_cnt, ftm);
      if (mode == 0 && wei == 2 && ftm == 5) chk("para_to_done", t_done - t_para, 23);
`ifdef CONV_BUFFER_LOADER_STALL_CNT_EN
      if (mode == 5) chk("stall_cnt", stall_cnt, 7);
`endif
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_rst_busy", busy, 0);
    chk("in_rst_s_ready", s_ready, 0);
    chk("in_rst_wb_we", wb_we, 0);
    @(posedge clk); #3;
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_para", para, 0);
    chk("rst_di", di, 0);
    chk("rst_strobes", {para_we, fb_clr, wb_clr, fb_we, wb_we, done, s_ready}, 0);
    @(posedge clk); #1;
    run_cmd(2, 5, 0);
    run_cmd(2, 4, 2);
    run_cmd(0, 3, 0);
    run_cmd(1, 6, 3);
    run_cmd(1, 2, 0);
    run_cmd(1, 2, 4);
    chk("hold_cmd_ready_after_done", cmd_ready, 1);
    chk("hold_para_we_after_done", para_we, 0);
    run_cmd(2, 3, 0);
    for (int k = 0; k < 6; k++) run_cmd($urandom_range(0, 3), $urandom_range(0, 8), 1);
`ifdef CONV_BUFFER_LOADER_STALL_CNT_EN
    run_cmd(0, 6, 5);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
